// File: rtl/instr_aligner_if.sv
// Fetch-side and decode-side handshake bundle for instr_aligner.
// The aligner connects through the slave modport; the fetch/decode side uses master.
interface instr_aligner_if;
   logic        s_flush_i;
   logic [31:0] s_flush_addr_i;
   logic        s_fetch_val_i;
   logic [31:0] s_fetch_data_i;
   logic        s_fetch_pred_i;
   logic        s_fetch_rdy_o;
   logic        s_instr_val_o;
   logic [31:0] s_instr_o;
   logic        s_instr_rvc_o;
   logic [31:0] s_instr_pc_o;
   logic        s_instr_pred_o;
   logic        s_instr_rdy_i;

   modport master (
      output s_flush_i,
      output s_flush_addr_i,
      output s_fetch_val_i,
      output s_fetch_data_i,
      output s_fetch_pred_i,
      input  s_fetch_rdy_o,
      input  s_instr_val_o,
      input  s_instr_o,
      input  s_instr_rvc_o,
      input  s_instr_pc_o,
      input  s_instr_pred_o,
      output s_instr_rdy_i
   );

   modport slave (
      input  s_flush_i,
      input  s_flush_addr_i,
      input  s_fetch_val_i,
      input  s_fetch_data_i,
      input  s_fetch_pred_i,
      output s_fetch_rdy_o,
      output s_instr_val_o,
      output s_instr_o,
      output s_instr_rvc_o,
      output s_instr_pc_o,
      output s_instr_pred_o,
      input  s_instr_rdy_i
   );
endinterface

// File: rtl/instr_aligner.sv
// Splits word-aligned fetch words into whole RVC / 32-bit instructions with PC.
// Define ALIGNER_PRED_EN to carry the fetch prediction bit through to instructions.
module instr_aligner #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic              s_clk_i,
   input  logic              s_resetn_i,
   instr_aligner_if.slave    bus
);

   typedef enum logic [1:0] {StAligned, StHalf, StSkip} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q;
   logic [15:0] hb_q, hb_d;
   logic        instr_val_q;
   logic [31:0] instr_q, instr_d;
   logic        instr_rvc_q, instr_rvc_d;
   logic [31:0] instr_pc_q;

   logic        advance;
   logic        hb_is32;
   logic        w_is32;
   logic        needs_w;
   logic        take;
   logic        fire;
   logic        emit;
   logic [31:0] w;

   assign w       = bus.s_fetch_data_i;
   assign advance = ~instr_val_q | bus.s_instr_rdy_i;
   assign hb_is32 = (hb_q[1:0] == 2'b11);
   assign w_is32  = (w[1:0] == 2'b11);

   // Only a pending RVC in hb can be emitted without a new word; keeps rdy off the data path.
   assign needs_w = ~((state_q == StHalf) & ~hb_is32);
   assign take    = advance & ~bus.s_flush_i & needs_w & bus.s_fetch_val_i;

   assign bus.s_fetch_rdy_o  = take;
   assign bus.s_instr_val_o  = instr_val_q;
   assign bus.s_instr_o      = instr_q;
   assign bus.s_instr_rvc_o  = instr_rvc_q;
   assign bus.s_instr_pc_o   = instr_pc_q;

   always_comb begin
      state_d     = state_q;
      hb_d        = hb_q;
      instr_d     = '0;
      instr_rvc_d = 1'b0;
      fire        = 1'b0;
      emit        = 1'b0;
      unique case (state_q)
         StAligned: begin
            fire = take;
            emit = take;
            if (w_is32) begin
               instr_d = w;
            end else begin
               instr_d     = {16'h0000, w[15:0]};
               instr_rvc_d = 1'b1;
               hb_d        = w[31:16];
               state_d     = StHalf;
            end
         end
         StHalf: begin
            if (!hb_is32) begin
               fire        = advance & ~bus.s_flush_i;
               emit        = fire;
               instr_d     = {16'h0000, hb_q};
               instr_rvc_d = 1'b1;
               state_d     = StAligned;
            end else begin
               fire    = take;
               emit    = take;
               instr_d = {w[15:0], hb_q};
               hb_d    = w[31:16];
            end
         end
         StSkip: begin
            fire    = take;
            hb_d    = w[31:16];
            state_d = StHalf;
         end
         default: ;
      endcase
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q     <= StAligned;
         pc_q        <= BOOT_ADDR;
         hb_q        <= '0;
         instr_val_q <= 1'b0;
         instr_q     <= '0;
         instr_rvc_q <= 1'b0;
         instr_pc_q  <= '0;
      end else if (bus.s_flush_i) begin
         pc_q        <= {bus.s_flush_addr_i[31:1], 1'b0};
         state_q     <= bus.s_flush_addr_i[1] ? StSkip : StAligned;
         hb_q        <= '0;
         instr_val_q <= 1'b0;
      end else begin
         if (fire) begin
            state_q <= state_d;
            hb_q    <= hb_d;
         end
         if (advance) begin
            instr_val_q <= emit;
            if (emit) begin
               instr_q     <= instr_d;
               instr_rvc_q <= instr_rvc_d;
               instr_pc_q  <= pc_q;
               pc_q        <= pc_q + (instr_rvc_d ? 32'd2 : 32'd4);
            end
         end
      end
   end

   logic unused_addr;
   assign unused_addr = bus.s_flush_addr_i[0];

`ifdef ALIGNER_PRED_EN
   logic hp_q, hp_d;
   logic pred_emit;
   logic instr_pred_q;

   // The word's bit follows its upper halfword, including a 32-bit instruction starting there.
   always_comb begin
      hp_d      = hp_q;
      pred_emit = 1'b0;
      unique case (state_q)
         StAligned: begin
            if (w_is32) pred_emit = bus.s_fetch_pred_i;
            else        hp_d      = bus.s_fetch_pred_i;
         end
         StHalf: begin
            pred_emit = hp_q;
            if (hb_is32) hp_d = bus.s_fetch_pred_i;
         end
         StSkip:  hp_d = bus.s_fetch_pred_i;
         default: ;
      endcase
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         hp_q         <= 1'b0;
         instr_pred_q <= 1'b0;
      end else if (bus.s_flush_i) begin
         hp_q <= 1'b0;
      end else begin
         if (fire) hp_q <= hp_d;
         if (advance && emit) instr_pred_q <= pred_emit;
      end
   end

   assign bus.s_instr_pred_o = instr_pred_q;
`else
   logic unused_pred;
   assign unused_pred        = bus.s_fetch_pred_i;
   assign bus.s_instr_pred_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_aligner.sv
// Directed vector table plus randomized run against a halfword-stream reference model.
module tb_instr_aligner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_aligner_if bus ();

   instr_aligner #(
      .BOOT_ADDR (32'h0000_0100)
   ) dut (
      .s_clk_i    (clk),
      .s_resetn_i (rst_n),
      .bus        (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic pred_exp(input logic p);
`ifdef ALIGNER_PRED_EN
      return p;
`else
      return 1'b0;
`endif
   endfunction

   typedef struct {
      logic        flush;
      logic [31:0] faddr;
      logic        fval;
      logic [31:0] fdata;
      logic        fpred;
      logic        irdy;
      logic        exp_frdy;
      logic        exp_val;
      logic        chk_data;
      logic [31:0] exp_instr;
      logic        exp_rvc;
      logic [31:0] exp_pc;
      logic        exp_pred;
   } vec_t;

   vec_t vt [18];

   task automatic drive(input logic fl, input logic [31:0] fa, input logic fv,
                        input logic [31:0] fd, input logic fp, input logic ir);
      bus.s_flush_i      = fl;
      bus.s_flush_addr_i = fa;
      bus.s_fetch_val_i  = fv;
      bus.s_fetch_data_i = fd;
      bus.s_fetch_pred_i = fp;
      bus.s_instr_rdy_i  = ir;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      drive(v.flush, v.faddr, v.fval, v.fdata, v.fpred, v.irdy);
      #1;
      chk($sformatf("v%0d_fetch_rdy", idx), {31'b0, bus.s_fetch_rdy_o}, {31'b0, v.exp_frdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_val", idx), {31'b0, bus.s_instr_val_o}, {31'b0, v.exp_val});
      if (v.chk_data) begin
         chk($sformatf("v%0d_instr", idx), bus.s_instr_o, v.exp_instr);
         chk($sformatf("v%0d_rvc", idx), {31'b0, bus.s_instr_rvc_o}, {31'b0, v.exp_rvc});
         chk($sformatf("v%0d_pc", idx), bus.s_instr_pc_o, v.exp_pc);
         chk($sformatf("v%0d_pred", idx), {31'b0, bus.s_instr_pred_o},
             {31'b0, pred_exp(v.exp_pred)});
      end
   endtask

   // Reference model: halfword stream with per-halfword prediction flags.
   logic [15:0] hq [$];
   logic        hqp [$];
   typedef struct {
      logic [31:0] instr;
      logic        rvc;
      logic [31:0] pc;
      logic        pred;
   } exp_t;
   exp_t        eq [$];
   logic [31:0] mpc;
   logic        mskip;

   function automatic logic [15:0] rand_hw();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else h[1:0] = 2'($urandom_range(0, 2));
      return h;
   endfunction

   task automatic model_word(input logic [31:0] wd, input logic p);
      exp_t e;
      if (!mskip) begin
         hq.push_back(wd[15:0]);
         hqp.push_back(1'b0);
      end
      mskip = 1'b0;
      hq.push_back(wd[31:16]);
      hqp.push_back(p);
      while (hq.size() > 0) begin
         if (hq[0][1:0] != 2'b11) begin
            e = '{instr: {16'h0, hq[0]}, rvc: 1'b1, pc: mpc, pred: hqp[0]};
            void'(hq.pop_front());
            void'(hqp.pop_front());
            mpc += 32'd2;
            eq.push_back(e);
         end else if (hq.size() >= 2) begin
            e = '{instr: {hq[1], hq[0]}, rvc: 1'b0, pc: mpc, pred: hqp[0] | hqp[1]};
            repeat (2) begin
               void'(hq.pop_front());
               void'(hqp.pop_front());
            end
            mpc += 32'd4;
            eq.push_back(e);
         end else begin
            break;
         end
      end
   endtask

   initial begin
      int emitted;
      exp_t e;
      logic fl, fv, fp, ir;
      logic [31:0] fa, fd;

      vt[0]  = '{0, 0, 1, 32'h00A00093, 0, 1, 1, 1, 1, 32'h00A00093, 0, 32'h100, 0};
      vt[1]  = '{0, 0, 1, 32'h45014081, 1, 1, 1, 1, 1, 32'h00004081, 1, 32'h104, 0};
      vt[2]  = '{0, 0, 1, 32'h00934505, 0, 1, 0, 1, 1, 32'h00004501, 1, 32'h106, 1};
      vt[3]  = '{0, 0, 1, 32'h00934505, 0, 1, 1, 1, 1, 32'h00004505, 1, 32'h108, 0};
      vt[4]  = '{0, 0, 1, 32'h000100A0, 0, 1, 1, 1, 1, 32'h00A00093, 0, 32'h10A, 0};
      vt[5]  = '{0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'h00000001, 1, 32'h10E, 0};
      vt[6]  = '{0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h00000001, 1, 32'h10E, 0};
      vt[7]  = '{0, 0, 1, 32'h12345678, 0, 0, 0, 1, 1, 32'h00000001, 1, 32'h10E, 0};
      vt[8]  = '{1, 32'h203, 1, 32'h4585FFFF, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0};
      vt[9]  = '{0, 0, 1, 32'h4585FFFF, 1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0};
      vt[10] = '{0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'h00004585, 1, 32'h202, 1};
      vt[11] = '{0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0};
      vt[12] = '{1, 32'h300, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0};
      vt[13] = '{0, 0, 1, 32'hFFFFFFFF, 1, 1, 1, 1, 1, 32'hFFFFFFFF, 0, 32'h300, 1};
      vt[14] = '{1, 32'hFFFFFFFE, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0};
      vt[15] = '{0, 0, 1, 32'h40810000, 0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0};
      vt[16] = '{0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'h00004081, 1, 32'hFFFFFFFE, 0};
      vt[17] = '{0, 0, 1, 32'h00A00093, 0, 1, 1, 1, 1, 32'h00A00093, 0, 32'h00000000, 0};

      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_val", {31'b0, bus.s_instr_val_o}, 32'd0);
      chk("rst_instr", bus.s_instr_o, 32'd0);
      chk("rst_rvc", {31'b0, bus.s_instr_rvc_o}, 32'd0);
      chk("rst_pc", bus.s_instr_pc_o, 32'd0);
      chk("rst_pred", {31'b0, bus.s_instr_pred_o}, 32'd0);
      chk("rst_fetch_rdy", {31'b0, bus.s_fetch_rdy_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) apply(vt[i], i);

      // Reset mid-operation with an RVC still buffered: it must never appear.
      apply('{0, 0, 1, 32'h45014081, 0, 1, 1, 1, 1, 32'h00004081, 1, 32'h4, 0}, 100);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_val", {31'b0, bus.s_instr_val_o}, 32'd0);
      chk("midrst_pc", bus.s_instr_pc_o, 32'd0);
      drive(0, 0, 0, 0, 0, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      apply('{0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0}, 101);
      apply('{0, 0, 1, 32'h00A00093, 0, 1, 1, 1, 1, 32'h00A00093, 0, 32'h100, 0}, 102);

      // Randomized run.
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      hq.delete();
      hqp.delete();
      eq.delete();
      mpc = 32'h100;
      mskip = 1'b0;
      emitted = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (cyc < 3970) begin
            fl = ($urandom_range(0, 39) == 0);
            fa = $urandom;
            fv = ($urandom_range(0, 9) < 7);
            fd = {rand_hw(), rand_hw()};
            fp = 1'($urandom);
            ir = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
         end else begin
            fl = 0; fa = 0; fv = 0; fd = 0; fp = 0; ir = 1;
         end
         drive(fl, fa, fv, fd, fp, ir);
         #1;
         if (fl) chk("rnd_flush_rdy", {31'b0, bus.s_fetch_rdy_o}, 32'd0);
         if (bus.s_instr_val_o && ir) begin
            if (eq.size() == 0) begin
               chk("rnd_extra_instr", bus.s_instr_o, 32'hDEAD_0000);
            end else begin
               e = eq.pop_front();
               emitted++;
               chk("rnd_instr", bus.s_instr_o, e.instr);
               chk("rnd_pc", bus.s_instr_pc_o, e.pc);
               chk("rnd_flags", {30'b0, bus.s_instr_rvc_o, bus.s_instr_pred_o},
                   {30'b0, e.rvc, pred_exp(e.pred)});
            end
         end
         if (fl) begin
            hq.delete();
            hqp.delete();
            eq.delete();
            mpc = {fa[31:1], 1'b0};
            mskip = fa[1];
         end else if (fv && bus.s_fetch_rdy_o) begin
            model_word(fd, fp);
         end
         @(posedge clk);
      end
      chk("rnd_drained", eq.size(), 32'd0);
      chk("rnd_progress", {31'b0, emitted > 1000}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
